hamming_enc_engine: RTL

Hardware SECDED encoder stage feeding the Hamming decoder program. On `start`, it reads 15 packed 11-bit messages from byte-wide data memory. It inserts Hamming parity bits p8/p4/p2/p1 plus overall parity p0 into each message, and writes the 16-bit codewords to the buffer the decoder consumes (addresses 30..59). It is a memory-mapped sequencer sitting beside the core on the `dm1` data-memory port, replacing the software encoder pass.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_enc11.sv | 16 +
 rtl/hamming_enc_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SECDED encoder definitions
//
// Purpose: state encoding, run geometry defaults and the 11->16 bit
// SECDED encode function shared by the encoder engine, the decoder
// checker and benches.
// Ports: none (package).
package hamming_pkg;

  localparam int NUM_MSG_DEFAULT  = 15;
  localparam int SRC_BASE_DEFAULT = 0;
  localparam int DST_BASE_DEFAULT = 30;
  localparam int AW_DEFAULT       = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RD_LO = 3'd1;
  localparam state_t S_RD_HI = 3'd2;
  localparam state_t S_CAP   = 3'd3;
  localparam state_t S_WR_LO = 3'd4;
  localparam state_t S_WR_HI = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  // Codeword bit k (k=1..15) is Hamming position k; bit 0 is overall parity.
  function automatic logic [15:0] hamming_encode11(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc11.sv
// rtl/hamming_enc11.sv - combinational 11-bit to 16-bit SECDED encoder
//
// Purpose: thin wrapper around hamming_encode11.
// Ports:
//   data     in  11  message bits d[11:1]
//   codeword out 16  {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}
module hamming_enc11
  import hamming_pkg::*;
(
  input  logic [10:0] data,
  output logic [15:0] codeword
);

  assign codeword = hamming_encode11(data);

endmodule

// File: rtl/hamming_enc_engine.sv
// rtl/hamming_enc_engine.sv - memory-mapped SECDED encoder sequencer
//
// Purpose: on start, reads NUM_MSG packed 11-bit messages from SRC_BASE,
// encodes each and writes the 16-bit codewords to DST_BASE, 5 cycles per
// message.
// Ports:
//   clk        in      clock, rising edge
//   reset      in      synchronous active-low reset
//   start      in      run request, honoured only in IDLE or DONE
//   busy       out     run in progress
//   done       out     run complete, held until next accepted start
//   mem_addr   out AW  byte address
//   mem_rd_en  out     read strobe, data returns next cycle
//   mem_rdata  in  8   read data
//   mem_wr_en  out     write strobe
//   mem_wdata  out 8   write data
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = NUM_MSG_DEFAULT,
  parameter int SRC_BASE = SRC_BASE_DEFAULT,
  parameter int DST_BASE = DST_BASE_DEFAULT,
  parameter int AW       = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata
);

  localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    lo_q;
  logic [15:0]   cw_q;
  logic [15:0]   enc_cw;
  logic [AW-1:0] offset;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;

  // During CAP the high byte is on mem_rdata; only bits [2:0] carry data.
  hamming_enc11 u_enc (
    .data     ({mem_rdata[2:0], lo_q}),
    .codeword (enc_cw)
  );

  // Byte offset 2*i; sums wrap modulo 2^AW by construction.
  assign offset   = AW'({idx, 1'b0});
  assign src_addr = AW'(SRC_BASE) + offset;
  assign dst_addr = AW'(DST_BASE) + offset;

  assign busy = (state == S_RD_LO) || (state == S_RD_HI) || (state == S_CAP) ||
                (state == S_WR_LO) || (state == S_WR_HI);
  assign done = (state == S_DONE);

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state)
      S_RD_LO: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr;
      end
      S_RD_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr + AW'(1);
      end
      S_WR_LO: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = cw_q[7:0];
      end
      S_WR_HI: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr + AW'(1);
        mem_wdata = cw_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      lo_q  <= '0;
      cw_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RD_LO;
            idx   <= '0;
          end
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: begin
          lo_q  <= mem_rdata;
          state <= S_CAP;
        end
        S_CAP: begin
          cw_q  <= enc_cw;
          state <= S_WR_LO;
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          if (idx == IW'(NUM_MSG - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_RD_LO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
